bf16_pack_fifo: RTL and testbench
=================================

BF16_PACK_FIFO -- requirements
Module: bf16_pack_fifo

Interface
REQ-001 The block SHALL have parameter MAN_WIDTH, default 7, bfloat16 mantissa field width.
REQ-002 The block SHALL have parameter EXP_WIDTH, default 8, bfloat16 exponent field width.
REQ-003 The block SHALL have parameter DEPTH, default 4, number of buffered result words; power of two, at least 2.
REQ-004 The block SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port valid_i  input  1  one-cycle strobe: sgn_i/exp_i/mantissa_i hold a new result.
REQ-007 The block SHALL have port sgn_i  input  1  result sign.
REQ-008 The block SHALL have port exp_i  input  EXP_WIDTH  biased result exponent.
REQ-009 The block SHALL have port mantissa_i  input  MAN_WIDTH  result fraction, hidden bit excluded.
REQ-010 The block SHALL have port ready_i  input  1  downstream accepts data_o this cycle.
REQ-011 The block SHALL have port valid_o  output  1  data_o holds a buffered word.
REQ-012 The block SHALL have port data_o  output  1+EXP_WIDTH+MAN_WIDTH  packed word {sign, exponent, mantissa}.
REQ-013 The block SHALL have port count_o  output  log2(DEPTH)+1  words currently buffered.
REQ-014 The block SHALL have port full_o  output  1  count_o equals DEPTH.
REQ-015 The block SHALL have port ovf_o  output  1  sticky: at least one word dropped since reset.

Function
REQ-016 Packing SHALL be {sgn_i, exp_i, mantissa_i}, MSB first, for a 16-bit word at defaults.
REQ-017 When exp_i is 0 the stored mantissa field SHALL be forced to 0 (denormals flushed to signed zero); sign and exponent are stored unchanged.
REQ-018 Push SHALL occur on a rising edge where valid_i is 1 and either count_o < DEPTH or a pop occurs in that same cycle.
REQ-019 Pop SHALL occur on a rising edge where valid_o and ready_i are both 1; the head word is removed.
REQ-020 Simultaneous push and pop SHALL leave count_o unchanged, both operations completing, including when full.
REQ-021 valid_i with count_o = DEPTH and no pop in that cycle SHALL drop the word, leave buffer and count unchanged, and set ovf_o to 1.
REQ-022 ovf_o SHALL remain 1 until reset.
REQ-023 A word pushed at edge N SHALL appear on data_o with valid_o = 1 after edge N when the buffer was empty before that edge (latency 1 cycle).
REQ-024 Words SHALL leave in push order; read and write pointers wrap modulo DEPTH.
REQ-025 valid_o SHALL equal (count_o != 0); full_o SHALL equal (count_o == DEPTH); both derived from registered count.
REQ-026 data_o SHALL be all zeros when valid_o is 0.
REQ-027 data_o and valid_o SHALL hold stable while valid_o is 1 and ready_i is 0.
REQ-028 valid_i on consecutive cycles SHALL be treated as separate words; no minimum spacing applies.
REQ-029 ready_i while empty SHALL have no effect.

Reset
REQ-030 While rst is 0: valid_o, data_o, count_o, full_o, ovf_o SHALL be 0, pointers 0; storage contents unspecified.
REQ-031 Reset asserted mid-operation SHALL discard all buffered words immediately, without waiting for a clock edge.
REQ-032 Pushes SHALL be accepted from the first rising edge after rst returns to 1.

Verification
REQ-033 Single push: sgn=0, exp=0x7F, mant=0x40, ready_i=1 -> next cycle valid_o=1, data_o=0x3FC0; following cycle valid_o=0, data_o=0x0000.
REQ-034 Denormal flush: sgn=1, exp=0x00, mant=0x55 -> data_o=0x8000.
REQ-035 Fill and overflow: ready_i=0, five pushes 0x3F80,0x4000,0x4040,0x4080,0x40A0 -> full_o=1 after fourth, ovf_o=1 after fifth, count_o=4; drain with ready_i=1 -> 0x3F80,0x4000,0x4040,0x4080 in order, 0x40A0 never appears, ovf_o stays 1.
REQ-036 Full with simultaneous push/pop: full buffer, ready_i=1, push 0xC000 -> no drop, ovf_o unchanged, count_o=4, 0xC000 emerges fourth.
REQ-037 Wrap: ten push/pop pairs through DEPTH=4 -> output order equals input order, count_o never exceeds 4.
REQ-038 Mid-stream reset: three words buffered, rst=0 between edges -> valid_o, count_o, ovf_o, data_o 0 at once; next push after release emerges alone.

Source files
------------

// File: rtl/bf16_pack_fifo.sv
// Packs bfloat16 result fields into {sign, exponent, mantissa} words and buffers
// them in a small FIFO with a sticky overflow flag for words dropped while full.
module bf16_pack_fifo #(
   parameter int MAN_WIDTH = 7,
   parameter int EXP_WIDTH = 8,
   parameter int DEPTH     = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           valid_i,
   input  logic                           sgn_i,
   input  logic [EXP_WIDTH-1:0]           exp_i,
   input  logic [MAN_WIDTH-1:0]           mantissa_i,
   input  logic                           ready_i,
   output logic                           valid_o,
   output logic [EXP_WIDTH+MAN_WIDTH:0]   data_o,
   output logic [$clog2(DEPTH):0]         count_o,
   output logic                           full_o,
   output logic                           ovf_o
);

   localparam int W  = 1 + EXP_WIDTH + MAN_WIDTH;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [W-1:0]    mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic            ovf;
   logic            push;
   logic            pop;
   logic [W-1:0]    packed_word;

   // Handshake: a word leaves on a rising edge where valid_o && ready_i; an
   // incoming word is taken whenever there is room or a pop frees a slot in the
   // same cycle, otherwise it is dropped and ovf_o latches high until reset.
   always_comb begin
      pop  = (count != '0) && ready_i;
      push = valid_i && ((count != FULL_CNT) || pop);
   end

   // Zero exponent means denormal: flush the fraction to get a signed zero.
   always_comb begin
      packed_word = {sgn_i, exp_i, mantissa_i};
      if (exp_i == '0)
         packed_word[MAN_WIDTH-1:0] = '0;
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= packed_word;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)
            count <= count + CW'(1);
         else if (pop && !push)
            count <= count - CW'(1);
         if (valid_i && !push)
            ovf <= 1'b1;
      end
   end

   always_comb begin
      valid_o = (count != '0);
      full_o  = (count == FULL_CNT);
      count_o = count;
      ovf_o   = ovf;
      data_o  = valid_o ? mem[rd_ptr] : '0;
   end

endmodule

// File: tb/tb_bf16_pack_fifo.sv
// Self-checking bench for bf16_pack_fifo: directed scenarios plus randomized
// traffic compared against a queue-based reference model of the buffer.
module tb_bf16_pack_fifo;

   localparam int DEPTH = 4;
   localparam int W     = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          valid_i = 1'b0;
   logic          sgn_i = 1'b0;
   logic [7:0]    exp_i = '0;
   logic [6:0]    mantissa_i = '0;
   logic          ready_i = 1'b0;
   logic          valid_o;
   logic [15:0]   data_o;
   logic [2:0]    count_o;
   logic          full_o;
   logic          ovf_o;

   logic [W-1:0]  exp_q[$];
   logic          model_ovf = 1'b0;
   int            n_checks = 0;
   int            n_fail = 0;

   bf16_pack_fifo dut (
      .clk        (clk),
      .rst        (rst),
      .valid_i    (valid_i),
      .sgn_i      (sgn_i),
      .exp_i      (exp_i),
      .mantissa_i (mantissa_i),
      .ready_i    (ready_i),
      .valid_o    (valid_o),
      .data_o     (data_o),
      .count_o    (count_o),
      .full_o     (full_o),
      .ovf_o      (ovf_o)
   );

   // clock / reset
   always #5 clk = ~clk;

   // reference model
   function automatic logic [W-1:0] flush(input logic [W-1:0] raw);
      if (raw[14:7] == 8'd0)
         return raw & 16'hFF80;
      return raw;
   endfunction

   task automatic model_step(input logic v, input logic [W-1:0] raw, input logic r);
      bit do_pop;
      bit do_push;
      do_pop  = (exp_q.size() > 0) && r;
      do_push = v && ((exp_q.size() < DEPTH) || do_pop);
      if (do_pop)
         void'(exp_q.pop_front());
      if (do_push)
         exp_q.push_back(flush(raw));
      if (v && !do_push)
         model_ovf = 1'b1;
   endtask

   function automatic logic [21:0] expected_outputs();
      logic [15:0] d;
      d = (exp_q.size() > 0) ? exp_q[0] : 16'h0000;
      return {exp_q.size() != 0, 3'(exp_q.size()), exp_q.size() == DEPTH, model_ovf, d};
   endfunction

   // driver: present one cycle of stimulus, advance past the edge, update model
   task automatic tick(input logic v, input logic [W-1:0] raw, input logic r);
      valid_i    = v;
      sgn_i      = raw[15];
      exp_i      = raw[14:7];
      mantissa_i = raw[6:0];
      ready_i    = r;
      @(posedge clk);
      model_step(v, raw, r);
      #1;
      valid_i = 1'b0;
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      #1;
      exp_q.delete();
      model_ovf = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if ({valid_o, count_o, full_o, ovf_o, data_o} !== 22'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h want 0", {valid_o, count_o, full_o, ovf_o, data_o});
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic test_single_push();
      tick(1'b1, 16'h3FC0, 1'b1);
      n_checks++;
      if (valid_o !== 1'b1 || data_o !== 16'h3FC0) begin
         n_fail++;
         $display("FAIL single_push: valid %b data %h want 1 3fc0", valid_o, data_o);
      end
      tick(1'b0, 16'h0000, 1'b1);
      n_checks++;
      if (valid_o !== 1'b0 || data_o !== 16'h0000) begin
         n_fail++;
         $display("FAIL single_pop: valid %b data %h want 0 0000", valid_o, data_o);
      end
   endtask

   task automatic test_denormal();
      tick(1'b1, 16'h8055, 1'b0);
      n_checks++;
      if (data_o !== 16'h8000) begin
         n_fail++;
         $display("FAIL denormal_flush: data %h want 8000", data_o);
      end
      tick(1'b0, 16'h0000, 1'b1);
   endtask

   task automatic test_fill_overflow();
      logic [W-1:0] words [5];
      words = '{16'h3F80, 16'h4000, 16'h4040, 16'h4080, 16'h40A0};
      for (int i = 0; i < 5; i++) begin
         tick(1'b1, words[i], 1'b0);
         n_checks++;
         if (full_o !== (i >= 3) || ovf_o !== (i == 4) || data_o !== 16'h3F80) begin
            n_fail++;
            $display("FAIL fill_%0d: full %b ovf %b data %h want %b %b 3f80",
                     i, full_o, ovf_o, data_o, i >= 3, i == 4);
         end
      end
      n_checks++;
      if (count_o !== 3'd4) begin
         n_fail++;
         $display("FAIL fill_count: count %0d want 4", count_o);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (valid_o !== 1'b1 || data_o !== words[i] || ovf_o !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_%0d: valid %b data %h ovf %b want 1 %h 1", i, valid_o, data_o, ovf_o, words[i]);
         end
         tick(1'b0, 16'h0000, 1'b1);
      end
      n_checks++;
      if (valid_o !== 1'b0 || count_o !== 3'd0 || ovf_o !== 1'b1) begin
         n_fail++;
         $display("FAIL drain_end: valid %b count %0d ovf %b want 0 0 1", valid_o, count_o, ovf_o);
      end
   endtask

   task automatic test_full_push_pop();
      logic [W-1:0] words [4];
      words = '{16'h3F80, 16'h4000, 16'h4040, 16'h4080};
      apply_reset();
      for (int i = 0; i < 4; i++)
         tick(1'b1, words[i], 1'b0);
      tick(1'b1, 16'hC000, 1'b1);
      n_checks++;
      if (count_o !== 3'd4 || ovf_o !== 1'b0 || data_o !== 16'h4000) begin
         n_fail++;
         $display("FAIL full_push_pop: count %0d ovf %b data %h want 4 0 4000", count_o, ovf_o, data_o);
      end
      for (int i = 0; i < 3; i++)
         tick(1'b0, 16'h0000, 1'b1);
      n_checks++;
      if (data_o !== 16'hC000 || count_o !== 3'd1) begin
         n_fail++;
         $display("FAIL full_push_pop_order: data %h count %0d want c000 1", data_o, count_o);
      end
      tick(1'b0, 16'h0000, 1'b1);
   endtask

   task automatic test_wrap();
      logic [W-1:0] raw;
      for (int i = 0; i < 10; i++) begin
         raw = 16'($urandom_range(0, 16'hFFFF));
         tick(1'b1, raw, 1'b1);
         n_checks++;
         if ({valid_o, count_o, full_o, ovf_o, data_o} !== expected_outputs() || count_o > 3'd4) begin
            n_fail++;
            $display("FAIL wrap_%0d: got %h want %h", i, {valid_o, count_o, full_o, ovf_o, data_o}, expected_outputs());
         end
      end
      tick(1'b0, 16'h0000, 1'b1);
   endtask

   task automatic test_random();
      logic [W-1:0] raw;
      logic         v;
      logic         r;
      for (int i = 0; i < 300; i++) begin
         raw = 16'($urandom_range(0, 16'hFFFF));
         if ($urandom_range(0, 3) == 0)
            raw[14:7] = 8'd0;
         v = ($urandom_range(0, 99) < 60);
         r = ($urandom_range(0, 99) < 45);
         tick(v, raw, r);
         n_checks++;
         if ({valid_o, count_o, full_o, ovf_o, data_o} !== expected_outputs()) begin
            n_fail++;
            $display("FAIL random_%0d: got %h want %h", i, {valid_o, count_o, full_o, ovf_o, data_o}, expected_outputs());
         end
      end
   endtask

   task automatic test_mid_reset();
      apply_reset();
      tick(1'b1, 16'h3F80, 1'b0);
      tick(1'b1, 16'h4000, 1'b0);
      tick(1'b1, 16'h4040, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      n_checks++;
      if ({valid_o, count_o, full_o, ovf_o, data_o} !== 22'd0) begin
         n_fail++;
         $display("FAIL mid_reset_async: got %h want 0", {valid_o, count_o, full_o, ovf_o, data_o});
      end
      exp_q.delete();
      model_ovf = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      tick(1'b1, 16'h4480, 1'b0);
      n_checks++;
      if (valid_o !== 1'b1 || count_o !== 3'd1 || data_o !== 16'h4480) begin
         n_fail++;
         $display("FAIL mid_reset_push: valid %b count %0d data %h want 1 1 4480", valid_o, count_o, data_o);
      end
      tick(1'b0, 16'h0000, 1'b1);
      n_checks++;
      if (valid_o !== 1'b0 || data_o !== 16'h0000) begin
         n_fail++;
         $display("FAIL mid_reset_alone: valid %b data %h want 0 0000", valid_o, data_o);
      end
   endtask

   initial begin
      test_reset();
      test_single_push();
      test_denormal();
      test_fill_overflow();
      test_full_push_pop();
      test_wrap();
      test_random();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
